// File: rtl/ccd_clk_pkg.sv
// Shared constants for the CCD clock configuration path: widths, base phase step,
// loader FSM encodings and io pad indices.
package ccd_clk_pkg;

  localparam int unsigned FREQ_W   = 4;
  localparam int unsigned PASO_W   = 32;
  localparam logic [31:0] PASO_DEF = 32'h5FA4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_CALC  = 2'd2;
  localparam logic [1:0] ST_PEND  = 2'd3;

  localparam int unsigned PAD_CLK    = 25;
  localparam int unsigned PAD_EN     = 24;
  localparam int unsigned PAD_SER    = 23;
  localparam int unsigned PAD_LOAD   = 22;
  localparam int unsigned PAD_PHI_P  = 10;
  localparam int unsigned PAD_PHI_L1 = 11;
  localparam int unsigned PAD_PHI_L2 = 12;
  localparam int unsigned PAD_PHI_R  = 13;

endpackage

// File: rtl/pad_sync.sv
// Multi-flop synchronizer for a raw asynchronous pad input; resets to 0.
module pad_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], i_d};
    end
  end

  assign o_q = ff[STAGES-1];

endmodule

// File: rtl/ccd_clk_config_loader.sv
// Deserializes the frequency-select word, computes the phase step by shift-add and
// hands {freq_select, paso} to the generator only at a frame boundary or while disabled.
module ccd_clk_config_loader #(
  parameter int unsigned        FREQ_W      = ccd_clk_pkg::FREQ_W,
  parameter int unsigned        PASO_W      = ccd_clk_pkg::PASO_W,
  parameter logic [PASO_W-1:0]  PASO_DEF    = PASO_W'(ccd_clk_pkg::PASO_DEF),
  parameter int unsigned        SYNC_STAGES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load_config,
  input  logic              i_f_select_serial,
  input  logic              i_enable,
  input  logic              i_frame_boundary,
  output logic [FREQ_W-1:0] o_freq_select,
  output logic [PASO_W-1:0] o_paso,
  output logic              o_cfg_update,
  output logic              o_cfg_error,
  output logic              o_busy
);

  import ccd_clk_pkg::*;

  localparam int unsigned CNT_W = $clog2(FREQ_W + 2);

  logic load_s, data_s;

  pad_sync #(.STAGES(SYNC_STAGES)) u_sync_load (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_load_config),
    .o_q     (load_s)
  );

  pad_sync #(.STAGES(SYNC_STAGES)) u_sync_data (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_f_select_serial),
    .o_q     (data_s)
  );

  logic [1:0]        state_q, state_d;
  logic [FREQ_W-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [FREQ_W-1:0] staged_q, staged_d;
  logic [FREQ_W:0]   mult_q, mult_d;
  logic [PASO_W-1:0] addend_q, addend_d;
  logic [PASO_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  calc_cnt_q, calc_cnt_d;
  logic [FREQ_W-1:0] freq_q, freq_d;
  logic [PASO_W-1:0] paso_q, paso_d;
  logic              update_q, update_d;
  logic              error_q, error_d;

  logic [FREQ_W-1:0] sr_shifted;
  assign sr_shifted = {sr_q[FREQ_W-2:0], data_s};

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    staged_d   = staged_q;
    mult_d     = mult_q;
    addend_d   = addend_q;
    acc_d      = acc_q;
    calc_cnt_d = calc_cnt_q;
    freq_d     = freq_q;
    paso_d     = paso_q;
    update_d   = 1'b0;
    error_d    = error_q;

    case (state_q)
      ST_IDLE: begin
        if (load_s) begin
          state_d = ST_SHIFT;
          sr_d    = sr_shifted;
          cnt_d   = CNT_W'(1);
        end
      end

      ST_SHIFT: begin
        if (load_s) begin
          sr_d = sr_shifted;
          if (cnt_q < CNT_W'(FREQ_W + 1)) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (cnt_q >= CNT_W'(FREQ_W)) begin
          staged_d   = sr_q;
          error_d    = 1'b0;
          mult_d     = {1'b0, sr_q} + {{FREQ_W{1'b0}}, 1'b1};
          addend_d   = PASO_DEF;
          acc_d      = '0;
          calc_cnt_d = '0;
          state_d    = ST_CALC;
        end else begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end
      end

      ST_CALC: begin
        // Any high load_s here is a fresh window; it supersedes the staged config.
        if (load_s) begin
          state_d = ST_SHIFT;
          sr_d    = sr_shifted;
          cnt_d   = CNT_W'(1);
        end else begin
          if (mult_q[0]) begin
            acc_d = acc_q + addend_q;
          end
          addend_d   = addend_q << 1;
          mult_d     = mult_q >> 1;
          calc_cnt_d = calc_cnt_q + CNT_W'(1);
          if (calc_cnt_q == CNT_W'(FREQ_W)) begin
            state_d = ST_PEND;
          end
        end
      end

      ST_PEND: begin
        if (load_s) begin
          state_d = ST_SHIFT;
          sr_d    = sr_shifted;
          cnt_d   = CNT_W'(1);
        end else if (i_frame_boundary || !i_enable) begin
          freq_d   = staged_q;
          paso_d   = acc_q;
          update_d = 1'b1;
          state_d  = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      sr_q       <= '0;
      cnt_q      <= '0;
      staged_q   <= '0;
      mult_q     <= '0;
      addend_q   <= '0;
      acc_q      <= '0;
      calc_cnt_q <= '0;
      freq_q     <= '0;
      paso_q     <= PASO_DEF;
      update_q   <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      staged_q   <= staged_d;
      mult_q     <= mult_d;
      addend_q   <= addend_d;
      acc_q      <= acc_d;
      calc_cnt_q <= calc_cnt_d;
      freq_q     <= freq_d;
      paso_q     <= paso_d;
      update_q   <= update_d;
      error_q    <= error_d;
    end
  end

  assign o_freq_select = freq_q;
  assign o_paso        = paso_q;
  assign o_cfg_update  = update_q;
  assign o_cfg_error   = error_q;
  assign o_busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ccd_clk_config_loader.sv
// Directed bench for ccd_clk_config_loader with hand-computed expected values.
module tb_ccd_clk_config_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic        ser;
  logic        en;
  logic        fb;
  logic [3:0]  freq_sel;
  logic [31:0] paso;
  logic        upd;
  logic        err;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int upd_cnt = 0;
  int base;
  int cyc;

  ccd_clk_config_loader dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_load_config     (load),
    .i_f_select_serial (ser),
    .i_enable          (en),
    .i_frame_boundary  (fb),
    .o_freq_select     (freq_sel),
    .o_paso            (paso),
    .o_cfg_update      (upd),
    .o_cfg_error       (err),
    .o_busy            (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (upd === 1'b1) upd_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_window(input int n, input logic [7:0] bits);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      load = 1'b1;
      ser  = bits[n-1-i];
    end
    @(posedge clk); #1;
    load = 1'b0;
    ser  = 1'b0;
  endtask

  // Returns the negedge index (1-based) after the window drop at which update is seen, 0 if never.
  task automatic wait_update(output int c_out);
    c_out = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (upd === 1'b1) begin
        c_out = c;
        break;
      end
    end
  endtask

  task automatic boundary_pulse();
    @(posedge clk); #1;
    fb = 1'b1;
    @(posedge clk); #1;
    fb = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    load  = 1'b0;
    ser   = 1'b0;
    en    = 1'b0;
    fb    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_freq",  {28'd0, freq_sel}, 32'h0);
    check("rst_paso",  paso, 32'h5FA4);
    check("rst_upd",   {31'd0, upd}, 32'h0);
    check("rst_err",   {31'd0, err}, 32'h0);
    check("rst_busy",  {31'd0, busy}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    base = upd_cnt;
    repeat (10) @(negedge clk);
    check("idle_no_upd", upd_cnt - base, 0);
    check("idle_freq", {28'd0, freq_sel}, 32'h0);
    check("idle_paso", paso, 32'h5FA4);

    // Disabled generator: applies right after CALC. Drop->update = 2 sync + 1 + 5 calc + 1 edges.
    send_window(4, 8'b0001);
    wait_update(cyc);
    check("dis_latency", cyc, 10);
    check("dis_freq", {28'd0, freq_sel}, 32'h1);
    check("dis_paso", paso, 32'h0000BF48);
    @(negedge clk);
    check("dis_upd_one_cycle", {31'd0, upd}, 32'h0);
    check("dis_busy", {31'd0, busy}, 32'h0);

    // Enabled: holds in PEND until a frame boundary; boundary in IDLE is ignored.
    en = 1'b1;
    base = upd_cnt;
    boundary_pulse();
    send_window(4, 8'b0101);
    repeat (15) @(negedge clk);
    check("pend_no_upd", upd_cnt - base, 0);
    check("pend_busy", {31'd0, busy}, 32'h1);
    check("pend_freq_old", {28'd0, freq_sel}, 32'h1);
    boundary_pulse();
    @(negedge clk);
    check("fb_upd", {31'd0, upd}, 32'h1);
    check("fb_freq", {28'd0, freq_sel}, 32'h5);
    check("fb_paso", paso, 32'h00023DD8);

    // Short window flags error and leaves applied config alone.
    send_window(3, 8'b111);
    repeat (6) @(negedge clk);
    check("short_err", {31'd0, err}, 32'h1);
    check("short_freq", {28'd0, freq_sel}, 32'h5);
    check("short_paso", paso, 32'h00023DD8);
    check("short_busy", {31'd0, busy}, 32'h0);
    send_window(4, 8'b1111);
    repeat (15) @(negedge clk);
    check("err_cleared", {31'd0, err}, 32'h0);
    check("f_busy", {31'd0, busy}, 32'h1);
    boundary_pulse();
    @(negedge clk);
    check("f_upd", {31'd0, upd}, 32'h1);
    check("f_freq", {28'd0, freq_sel}, 32'hF);
    check("f_paso", paso, 32'h0005FA40);

    // Over-length window keeps the last four bits (0010).
    en = 1'b0;
    send_window(6, 8'b100010);
    wait_update(cyc);
    check("long_seen", {31'd0, (cyc != 0)}, 32'h1);
    check("long_freq", {28'd0, freq_sel}, 32'h2);
    check("long_paso", paso, 32'h00011EEC);

    // New window during PEND aborts staged config; then async reset mid-SHIFT.
    en = 1'b1;
    send_window(4, 8'b0011);
    repeat (15) @(negedge clk);
    check("abort_pend_busy", {31'd0, busy}, 32'h1);
    base = upd_cnt;
    @(posedge clk); #1;
    load = 1'b1;
    ser  = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("abort_shift_busy", {31'd0, busy}, 32'h1);
    check("abort_not_applied", {28'd0, freq_sel}, 32'h2);
    check("abort_no_upd", upd_cnt - base, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_freq", {28'd0, freq_sel}, 32'h0);
    check("arst_paso", paso, 32'h5FA4);
    check("arst_busy", {31'd0, busy}, 32'h0);
    check("arst_err",  {31'd0, err}, 32'h0);
    check("arst_upd",  {31'd0, upd}, 32'h0);
    load = 1'b0;
    ser  = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    base = upd_cnt;
    boundary_pulse();
    repeat (20) @(negedge clk);
    check("post_rst_no_upd", upd_cnt - base, 0);
    check("post_rst_freq", {28'd0, freq_sel}, 32'h0);
    check("post_rst_paso", paso, 32'h5FA4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
